// File: rtl/uart_baud_gen_param.sv
// Programmable UART baud tick generator: oversample, bit and mid-bit ticks from a runtime divisor.
// Optional fractional divisor accumulator enabled by defining UART_BAUD_FRAC_EN.
module uart_baud_gen_param #(
  parameter int DIV_WIDTH   = 16,
  parameter int DEFAULT_DIV = 27,
  parameter int OVERSAMPLE  = 16
`ifdef UART_BAUD_FRAC_EN
  ,
  parameter int FRAC_WIDTH  = 4
`endif
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 enable_i,
  input  logic                 resync_i,
  input  logic                 div_load_i,
  input  logic [DIV_WIDTH-1:0] div_value_i,
`ifdef UART_BAUD_FRAC_EN
  input  logic [FRAC_WIDTH-1:0] frac_value_i,
`endif
  output logic                 os_tick_o,
  output logic                 tx_tick_o,
  output logic                 mid_tick_o,
  output logic                 div_pending_o,
  output logic                 load_err_o
);

  localparam int                  OS_W    = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0]     OS_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0]     OS_MID  = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [DIV_WIDTH-1:0] DEF_DIV = DIV_WIDTH'(DEFAULT_DIV);

  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [OS_W-1:0]      os_cnt_q, os_cnt_d;
  logic [DIV_WIDTH-1:0] div_act_q, div_act_d;
  logic [DIV_WIDTH-1:0] div_shadow_q, div_shadow_d;
  logic                 div_pending_q, div_pending_d;
  logic                 os_tick_q, os_tick_d;
  logic                 tx_tick_q, tx_tick_d;
  logic                 mid_tick_q, mid_tick_d;
  logic                 load_err_q, load_err_d;

  logic                 stretch;
  logic [DIV_WIDTH:0]   term_cnt;
  logic                 wrap;
  logic                 apply;
  logic                 load_ok;

`ifdef UART_BAUD_FRAC_EN
  logic [FRAC_WIDTH-1:0] acc_q, acc_d;
  logic                  extra_q, extra_d;
  assign stretch = extra_q;
`else
  assign stretch = 1'b0;
`endif

  // Compare one bit wider so a stretched period at the maximum divisor cannot overflow.
  assign term_cnt = {1'b0, div_act_q} - (DIV_WIDTH + 1)'(1) + {{DIV_WIDTH{1'b0}}, stretch};
  // >= rather than == keeps the counter bounded if a smaller divisor lands while cnt is held.
  assign wrap     = ({1'b0, cnt_q} >= term_cnt);
  assign load_ok  = div_load_i && (div_value_i != '0);

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    cnt_d         = cnt_q;
    os_cnt_d      = os_cnt_q;
    div_act_d     = div_act_q;
    div_shadow_d  = div_shadow_q;
    div_pending_d = div_pending_q;
    os_tick_d     = 1'b0;
    tx_tick_d     = 1'b0;
    mid_tick_d    = 1'b0;
    load_err_d    = div_load_i && (div_value_i == '0);
    apply         = 1'b0;
`ifdef UART_BAUD_FRAC_EN
    acc_d         = acc_q;
    extra_d       = extra_q;
`endif

    if (resync_i) begin
      cnt_d    = '0;
      os_cnt_d = '0;
      apply    = 1'b1;
`ifdef UART_BAUD_FRAC_EN
      acc_d    = '0;
      extra_d  = 1'b0;
`endif
    end else if (enable_i) begin
      if (wrap) begin
        cnt_d      = '0;
        os_tick_d  = 1'b1;
        tx_tick_d  = (os_cnt_q == OS_LAST);
        mid_tick_d = (os_cnt_q == OS_MID);
        os_cnt_d   = os_cnt_q + OS_W'(1);
        apply      = 1'b1;
`ifdef UART_BAUD_FRAC_EN
        {extra_d, acc_d} = {1'b0, acc_q} + {1'b0, frac_value_i};
`endif
      end else begin
        cnt_d = cnt_q + DIV_WIDTH'(1);
      end
    end else begin
      // Counters are frozen, so the shadow can be promoted without disturbing a period.
      apply = 1'b1;
    end

    if (apply) begin
      div_act_d     = div_shadow_q;
      div_pending_d = 1'b0;
    end
    if (load_ok) begin
      div_shadow_d  = div_value_i;
      div_pending_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      cnt_q         <= '0;
      os_cnt_q      <= '0;
      div_act_q     <= DEF_DIV;
      div_shadow_q  <= DEF_DIV;
      div_pending_q <= 1'b0;
      os_tick_q     <= 1'b0;
      tx_tick_q     <= 1'b0;
      mid_tick_q    <= 1'b0;
      load_err_q    <= 1'b0;
`ifdef UART_BAUD_FRAC_EN
      acc_q         <= '0;
      extra_q       <= 1'b0;
`endif
    end else begin
      cnt_q         <= cnt_d;
      os_cnt_q      <= os_cnt_d;
      div_act_q     <= div_act_d;
      div_shadow_q  <= div_shadow_d;
      div_pending_q <= div_pending_d;
      os_tick_q     <= os_tick_d;
      tx_tick_q     <= tx_tick_d;
      mid_tick_q    <= mid_tick_d;
      load_err_q    <= load_err_d;
`ifdef UART_BAUD_FRAC_EN
      acc_q         <= acc_d;
      extra_q       <= extra_d;
`endif
    end
  end

  assign os_tick_o     = os_tick_q;
  assign tx_tick_o     = tx_tick_q;
  assign mid_tick_o    = mid_tick_q;
  assign div_pending_o = div_pending_q;
  assign load_err_o    = load_err_q;

endmodule

// File: tb/tb_uart_baud_gen_param.sv
// Self-checking bench for uart_baud_gen_param (default build, integer divisor only).
module tb_uart_baud_gen_param;

  localparam int OS      = 16;
  localparam int DEF_DIV = 27;

  logic        clock_i = 1'b0;
  logic        reset_i, enable_i, resync_i, div_load_i;
  logic [15:0] div_value_i;
  logic        os_tick_o, tx_tick_o, mid_tick_o, div_pending_o, load_err_o;

  int n_checks = 0;
  int n_fail   = 0;

  uart_baud_gen_param dut (
    .clock_i      (clock_i),
    .reset_i      (reset_i),
    .enable_i     (enable_i),
    .resync_i     (resync_i),
    .div_load_i   (div_load_i),
    .div_value_i  (div_value_i),
    .os_tick_o    (os_tick_o),
    .tx_tick_o    (tx_tick_o),
    .mid_tick_o   (mid_tick_o),
    .div_pending_o(div_pending_o),
    .load_err_o   (load_err_o)
  );

  always #5 clock_i = ~clock_i;

  // Reference model: elapsed enabled cycles in the period and os_ticks since phase zero.
  int m_phase, m_div_act, m_shadow, m_nticks;
  bit m_pend;
  bit e_os, e_tx, e_mid, e_pend, e_err;

  task automatic model_step(input bit rst, input bit en, input bit rs, input bit ld, input int val);
    bit apply;
    apply = 1'b0;
    e_os = 0; e_tx = 0; e_mid = 0; e_err = 0;
    if (rst) begin
      m_phase = 0; m_nticks = 0; m_div_act = DEF_DIV; m_shadow = DEF_DIV; m_pend = 0;
    end else begin
      if (rs) begin
        m_phase = 0; m_nticks = 0; apply = 1'b1;
      end else if (en) begin
        if (m_phase + 1 >= m_div_act) begin
          m_phase  = 0;
          m_nticks = m_nticks + 1;
          e_os     = 1;
          e_tx     = (m_nticks % OS) == 0;
          e_mid    = (m_nticks % OS) == OS / 2;
          apply    = 1'b1;
        end else begin
          m_phase = m_phase + 1;
        end
      end else begin
        apply = 1'b1;
      end
      if (apply) begin
        m_div_act = m_shadow;
        m_pend    = 0;
      end
      if (ld && val != 0) begin
        m_shadow = val;
        m_pend   = 1;
      end
      e_err = ld && (val == 0);
    end
    e_pend = m_pend;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    check("os_tick", 32'(os_tick_o), 32'(e_os));
    check("tx_tick", 32'(tx_tick_o), 32'(e_tx));
    check("mid_tick", 32'(mid_tick_o), 32'(e_mid));
    check("div_pending", 32'(div_pending_o), 32'(e_pend));
    check("load_err", 32'(load_err_o), 32'(e_err));
  endtask

  task automatic cyc(input bit rst, input bit en, input bit rs, input bit ld, input int val);
    reset_i     = rst;
    enable_i    = en;
    resync_i    = rs;
    div_load_i  = ld;
    div_value_i = 16'(val);
    model_step(rst, en, rs, ld, val);
    @(posedge clock_i);
    #1;
  endtask

  // Run enabled cycles until os_tick appears; n is the number of cycles taken.
  task automatic wait_os(input int limit, output int n);
    bit seen;
    seen = 1'b0;
    n = 0;
    while (!seen && n < limit) begin
      cyc(0, 1, 0, 0, 0);
      check_model();
      n++;
      seen = os_tick_o;
    end
    if (!seen) check("wait_os_timeout", 32'(0), 32'(1));
  endtask

  typedef struct {
    bit rst, en, rs, ld;
    int val;
    bit os, tx, mid, pend, err;
  } vec_t;

  function automatic vec_t mk(bit rst, bit en, bit rs, bit ld, int val,
                              bit os, bit tx, bit mid, bit pend, bit err);
    vec_t v;
    v.rst = rst; v.en = en; v.rs = rs; v.ld = ld; v.val = val;
    v.os = os; v.tx = tx; v.mid = mid; v.pend = pend; v.err = err;
    return v;
  endfunction

  initial begin
    vec_t tbl[14];
    int n, first_os, first_mid, first_tx, ticks;

    reset_i = 1; enable_i = 0; resync_i = 0; div_load_i = 0; div_value_i = '0;

    // Directed table: divisor 1 gives os_tick every enabled cycle.
    tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0, 1, 1, 0, 0, 0, 1, 0);
    tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 3; i <= 9; i++) tbl[i] = mk(0, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    tbl[10] = mk(0, 1, 0, 0, 0, 1, 0, 1, 0, 0);
    tbl[11] = mk(0, 1, 0, 1, 0, 1, 0, 0, 0, 1);
    tbl[12] = mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    tbl[13] = mk(0, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 14; i++) begin
      cyc(tbl[i].rst, tbl[i].en, tbl[i].rs, tbl[i].ld, tbl[i].val);
      check($sformatf("tbl%0d_os", i), 32'(os_tick_o), 32'(tbl[i].os));
      check($sformatf("tbl%0d_tx", i), 32'(tx_tick_o), 32'(tbl[i].tx));
      check($sformatf("tbl%0d_mid", i), 32'(mid_tick_o), 32'(tbl[i].mid));
      check($sformatf("tbl%0d_pend", i), 32'(div_pending_o), 32'(tbl[i].pend));
      check($sformatf("tbl%0d_err", i), 32'(load_err_o), 32'(tbl[i].err));
    end

    // Default divisor after reset: first os/mid/tx at 27/216/432 cycles.
    cyc(1, 0, 0, 0, 0);
    check_model();
    first_os = 0; first_mid = 0; first_tx = 0;
    for (int k = 1; k <= 440; k++) begin
      cyc(0, 1, 0, 0, 0);
      check_model();
      if (os_tick_o && first_os == 0) first_os = k;
      if (mid_tick_o && first_mid == 0) first_mid = k;
      if (tx_tick_o && first_tx == 0) first_tx = k;
    end
    check("first_os", 32'(first_os), 32'(27));
    check("first_mid", 32'(first_mid), 32'(216));
    check("first_tx", 32'(first_tx), 32'(432));

    // Rejected zero divisor: single-cycle load_err, period stays 27.
    wait_os(60, n);
    cyc(0, 1, 0, 1, 0);
    check_model();
    check("zero_load_err", 32'(load_err_o), 32'(1));
    cyc(0, 1, 0, 0, 0);
    check_model();
    check("zero_load_err_end", 32'(load_err_o), 32'(0));
    wait_os(60, n);
    check("zero_load_period", 32'(n + 2), 32'(27));

    // Load 5 at cnt=10: current 27-cycle period completes, then 5-cycle periods.
    for (int k = 0; k < 10; k++) begin
      cyc(0, 1, 0, 0, 0);
      check_model();
    end
    cyc(0, 1, 0, 1, 5);
    check_model();
    check("load5_pending", 32'(div_pending_o), 32'(1));
    wait_os(60, n);
    check("load5_finish", 32'(n + 1), 32'(17));
    check("load5_pending_clr", 32'(div_pending_o), 32'(0));
    wait_os(60, n);
    check("div5_period", 32'(n), 32'(5));

    // Divisor 4, resync at os_cnt=9.
    cyc(0, 1, 0, 1, 4);
    check_model();
    cyc(0, 1, 1, 0, 0);
    check_model();
    for (int k = 0; k < 9; k++) wait_os(60, n);
    cyc(0, 1, 1, 0, 0);
    check_model();
    check("resync_quiet", 32'({os_tick_o, tx_tick_o, mid_tick_o}), 32'(0));
    first_mid = 0; first_tx = 0;
    for (int k = 1; k <= 80 && first_tx == 0; k++) begin
      cyc(0, 1, 0, 0, 0);
      check_model();
      if (mid_tick_o && first_mid == 0) first_mid = k;
      if (tx_tick_o) first_tx = k;
    end
    check("resync_mid", 32'(first_mid), 32'(32));
    check("resync_tx", 32'(first_tx), 32'(64));

    // Divisor 3, enable low mid-period: split period totals 3 enabled cycles.
    cyc(0, 1, 0, 1, 3);
    check_model();
    cyc(0, 1, 1, 0, 0);
    check_model();
    cyc(0, 1, 0, 0, 0);
    check_model();
    ticks = 0;
    for (int k = 0; k < 10; k++) begin
      cyc(0, 0, 0, 0, 0);
      check_model();
      ticks += int'(os_tick_o) + int'(tx_tick_o) + int'(mid_tick_o);
    end
    check("hold_no_ticks", 32'(ticks), 32'(0));
    wait_os(20, n);
    check("hold_split_period", 32'(n + 1), 32'(3));

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      cyc(($urandom % 400) == 0, ($urandom % 8) != 0, ($urandom % 50) == 0,
          ($urandom % 30) == 0, int'($urandom % 7));
      check_model();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
